// File: rtl/fpu_pkg.sv
// Shared FPU definitions for the fadd/fmul/fdiv units.
//   - IEEE-754 single field widths, exponent bias, all-ones exponent
//   - fdiv sequencer state encoding
//   - fp32 pack/unpack helpers
// No ports: package only.
package fpu_pkg;

  localparam int EXP_W   = 8;
  localparam int MAN_W   = 23;
  localparam int BIAS    = 127;
  localparam logic [EXP_W-1:0] EXP_MAX = 8'hFF;

  // Quotient bits produced by the divider: 24 significand bits, one
  // normalisation bit (quotient of two [1,2) mantissas lies in (0.5,2)),
  // and one guard bit for rounding.
  localparam int FDIV_NQ = 26;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    NORM = 2'd2,
    DONE = 2'd3
  } fdiv_state_e;

  typedef struct packed {
    logic             sign;
    logic [EXP_W-1:0] exp;
    logic [MAN_W-1:0] man;
  } fp32_t;

  function automatic fp32_t fp_unpack(input logic [31:0] v);
    return fp32_t'(v);
  endfunction

  function automatic logic [31:0] fp_pack(input logic             s,
                                          input logic [EXP_W-1:0] e,
                                          input logic [MAN_W-1:0] m);
    return {s, e, m};
  endfunction

endpackage

// File: rtl/fdiv_round.sv
// Combinational normalise / round / special-case stage of fdiv_seq.
//   q   [25:0] : raw restoring-division quotient (bit 25 = integer bit)
//   e1, e2     : biased exponents of dividend and divisor
//   sy         : result sign
//   z, dz      : dividend is zero / divisor is zero
//   y   [31:0] : packed single-precision result
// Round-half-up on the guard bit; no subnormals, no NaN.
module fdiv_round
  import fpu_pkg::*;
(
  input  logic [25:0] q,
  input  logic [7:0]  e1,
  input  logic [7:0]  e2,
  input  logic        sy,
  input  logic        z,
  input  logic        dz,
  output logic [31:0] y
);

  logic [23:0]       mant;
  logic              g;
  logic [24:0]       mr;
  logic [22:0]       frac;
  logic signed [9:0] e;
  logic              unused_hidden;

  // Hidden bit of the rounded mantissa is implicit in the packed format.
  assign unused_hidden = mr[23];

  always_comb begin
    mant = '0;
    g    = 1'b0;
    e    = '0;
    mr   = '0;
    frac = '0;
    y    = '0;

    // Quotient >= 1 keeps the exponent difference; < 1 borrows one.
    if (q[25]) begin
      mant = q[25:2];
      g    = q[1];
      e    = signed'({2'b00, e1} - {2'b00, e2} + 10'(BIAS));
    end else begin
      mant = q[24:1];
      g    = q[0];
      e    = signed'({2'b00, e1} - {2'b00, e2} + 10'(BIAS - 1));
    end

    mr   = {1'b0, mant} + {24'd0, g};
    frac = mr[22:0];
    // Rounding carried out of the mantissa: value is exactly 2.0.
    if (mr[24]) begin
      frac = '0;
      e    = e + 10'sd1;
    end

    if (z)
      y = fp_pack(sy, 8'h00, 23'd0);
    else if (dz)
      y = fp_pack(sy, EXP_MAX, 23'd0);
    else if (e <= 10'sd0)
      y = fp_pack(sy, 8'h00, 23'd0);
    else if (e >= 10'sd255)
      y = fp_pack(sy, EXP_MAX, 23'd0);
    else
      y = fp_pack(sy, e[7:0], frac);
  end

endmodule

// File: rtl/fdiv_seq.sv
// Iterative single-precision divider, y = x1 / x2, restoring division
// retiring RADIX quotient bits per CALC cycle.
//   clk, rstn            : clock (rising edge), async active-low reset
//   in_valid / in_ready  : operand handshake; in_ready is high only in IDLE
//   x1, x2               : dividend, divisor (IEEE-754 single)
//   out_valid / out_ready: result handshake; y held while out_ready is low
//   y                    : quotient, updated only at the end of NORM
//   busy                 : high in CALC/NORM/DONE
// Handshake rule: a transfer happens on a rising edge where both valid
// and ready are high; valid, once raised by the producer, is held with
// stable data until that edge.
// Sequence: IDLE -> CALC (NQ/RADIX cycles) -> NORM -> DONE -> IDLE.
module fdiv_seq
  import fpu_pkg::*;
#(
  parameter int RADIX = 1
) (
  input  logic        clk,
  input  logic        rstn,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] x1,
  input  logic [31:0] x2,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] y,
  output logic        busy
);

  localparam int NQ    = FDIV_NQ;
  localparam int STEPS = NQ / RADIX;
  localparam logic [4:0] CNT_INIT = 5'(STEPS);

  if ((RADIX != 1) && (RADIX != 2)) begin : g_bad_radix
    $error("fdiv_seq: RADIX must be 1 or 2");
  end

  fdiv_state_e state;

  logic        sy;
  logic        z;
  logic        dz;
  logic [7:0]  e1_r;
  logic [7:0]  e2_r;
  logic [23:0] mb;
  logic [24:0] r;
  logic [25:0] q;
  logic [4:0]  cnt;

  logic        in_ready_r;
  logic        out_valid_r;
  logic        busy_r;
  logic [31:0] y_r;

  fp32_t       a;
  fp32_t       b;
  logic [24:0] r_nx;
  logic [25:0] q_nx;
  logic [31:0] y_nx;

  assign a = fp_unpack(x1);
  assign b = fp_unpack(x2);

  // RADIX restoring steps chained in one cycle. After a subtract the
  // remainder is below mb (< 2^24), so the left shift never loses a bit.
  always_comb begin
    r_nx = r;
    q_nx = q;
    for (int i = 0; i < RADIX; i++) begin
      if (r_nx >= {1'b0, mb}) begin
        q_nx = {q_nx[24:0], 1'b1};
        r_nx = r_nx - {1'b0, mb};
      end else begin
        q_nx = {q_nx[24:0], 1'b0};
      end
      r_nx = {r_nx[23:0], 1'b0};
    end
  end

  fdiv_round u_round (
    .q  (q),
    .e1 (e1_r),
    .e2 (e2_r),
    .sy (sy),
    .z  (z),
    .dz (dz),
    .y  (y_nx)
  );

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state       <= IDLE;
      sy          <= 1'b0;
      z           <= 1'b0;
      dz          <= 1'b0;
      e1_r        <= '0;
      e2_r        <= '0;
      mb          <= '0;
      r           <= '0;
      q           <= '0;
      cnt         <= '0;
      in_ready_r  <= 1'b1;
      out_valid_r <= 1'b0;
      busy_r      <= 1'b0;
      y_r         <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            sy         <= a.sign ^ b.sign;
            z          <= (a.exp == 8'h00);
            dz         <= (b.exp == 8'h00);
            e1_r       <= a.exp;
            e2_r       <= b.exp;
            mb         <= {1'b1, b.man};
            r          <= {2'b01, a.man};
            q          <= '0;
            cnt        <= CNT_INIT;
            in_ready_r <= 1'b0;
            busy_r     <= 1'b1;
            state      <= CALC;
          end
        end
        CALC: begin
          r   <= r_nx;
          q   <= q_nx;
          cnt <= cnt - 5'd1;
          if (cnt == 5'd1)
            state <= NORM;
        end
        NORM: begin
          y_r         <= y_nx;
          out_valid_r <= 1'b1;
          state       <= DONE;
        end
        DONE: begin
          if (out_ready) begin
            out_valid_r <= 1'b0;
            busy_r      <= 1'b0;
            in_ready_r  <= 1'b1;
            state       <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign in_ready  = in_ready_r;
  assign out_valid = out_valid_r;
  assign busy      = busy_r;
  assign y         = y_r;

endmodule

// File: tb/tb_fdiv_seq.sv
// Bench for fdiv_seq: one instance per legal RADIX, shared operand bus,
// per-instance handshake signals. Expected quotients are pushed on the
// accept edge and popped on the output handshake edge.
module tb_fdiv_seq;

  logic        clk;
  logic        rstn;
  logic [31:0] x1;
  logic [31:0] x2;
  logic        in_valid  [2];
  logic        in_ready  [2];
  logic        out_valid [2];
  logic        out_ready [2];
  logic        busy      [2];
  logic [31:0] y         [2];

  int checks   = 0;
  int failures = 0;
  logic [31:0] exp_q[$];

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  fdiv_seq #(.RADIX(1)) dut_r1 (
    .clk       (clk),
    .rstn      (rstn),
    .in_valid  (in_valid[0]),
    .in_ready  (in_ready[0]),
    .x1        (x1),
    .x2        (x2),
    .out_valid (out_valid[0]),
    .out_ready (out_ready[0]),
    .y         (y[0]),
    .busy      (busy[0])
  );

  fdiv_seq #(.RADIX(2)) dut_r2 (
    .clk       (clk),
    .rstn      (rstn),
    .in_valid  (in_valid[1]),
    .in_ready  (in_ready[1]),
    .x1        (x1),
    .x2        (x2),
    .out_valid (out_valid[1]),
    .out_ready (out_ready[1]),
    .y         (y[1]),
    .busy      (busy[1])
  );

  // ---------------- checking ----------------
  task automatic check_eq(input string tag, input logic [31:0] got,
                          input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %08h expected %08h", tag, got, exp);
    end
  endtask

  // Reference quotient: one wide integer division instead of iteration.
  function automatic logic [31:0] model(input logic [31:0] a,
                                        input logic [31:0] b);
    logic        s;
    logic [63:0] ma, mb, qq;
    logic [23:0] mant;
    logic        g;
    logic [24:0] mr;
    int          e;
    s = a[31] ^ b[31];
    if (a[30:23] == 8'd0) return {s, 31'd0};
    if (b[30:23] == 8'd0) return {s, 8'hFF, 23'd0};
    ma = {40'd0, 1'b1, a[22:0]};
    mb = {40'd0, 1'b1, b[22:0]};
    qq = (ma << 25) / mb;
    if (qq[25]) begin
      mant = qq[25:2]; g = qq[1];
      e = int'(a[30:23]) - int'(b[30:23]) + 127;
    end else begin
      mant = qq[24:1]; g = qq[0];
      e = int'(a[30:23]) - int'(b[30:23]) + 126;
    end
    mr = {1'b0, mant} + {24'd0, g};
    if (mr[24]) begin
      mr = 25'h0800000;
      e  = e + 1;
    end
    if (e <= 0)   return {s, 31'd0};
    if (e >= 255) return {s, 8'hFF, 23'd0};
    return {s, 8'(e), mr[22:0]};
  endfunction

  // ---------------- driver ----------------
  task automatic run_op(input int d, input logic [31:0] a, input logic [31:0] b,
                        input logic [31:0] exp_y, input int hold, input string tag);
    int          w;
    int          lat;
    int          exp_lat;
    logic        ok_busy;
    logic        ok_hold;
    logic [31:0] y_seen;
    exp_lat = (26 / (d + 1)) + 2;

    @(negedge clk);
    x1 = a; x2 = b; in_valid[d] = 1'b1;
    w = 0;
    while (!in_ready[d] && w < 50) begin
      @(negedge clk);
      w++;
    end
    check_eq({tag, " in_ready_before_accept"}, 32'(in_ready[d]), 32'd1);
    @(posedge clk);
    exp_q.push_back(exp_y);
    @(negedge clk);
    in_valid[d] = 1'b0;
    x1 = $urandom; x2 = $urandom;

    lat = 1;
    ok_busy = 1'b1;
    while (!out_valid[d] && lat < 100) begin
      if (in_ready[d] || !busy[d]) ok_busy = 1'b0;
      @(negedge clk);
      lat++;
    end
    check_eq({tag, " latency"}, 32'(lat), 32'(exp_lat));
    check_eq({tag, " busy_no_ready_during_op"}, 32'(ok_busy), 32'd1);

    y_seen  = y[d];
    ok_hold = 1'b1;
    for (int i = 0; i < hold; i++) begin
      in_valid[d] = 1'($urandom_range(0, 1));
      x1 = $urandom; x2 = $urandom;
      @(negedge clk);
      if (y[d] !== y_seen || !out_valid[d] || in_ready[d]) ok_hold = 1'b0;
    end
    in_valid[d] = 1'b0;
    if (hold > 0)
      check_eq({tag, " backpressure_stable"}, 32'(ok_hold), 32'd1);

    out_ready[d] = 1'b1;
    y_seen = y[d];
    @(posedge clk);
    if (exp_q.size() == 0)
      check_eq({tag, " scoreboard_empty"}, 32'(exp_q.size()), 32'd1);
    else
      check_eq({tag, " y"}, y_seen, exp_q.pop_front());
    @(negedge clk);
    out_ready[d] = 1'b0;
    check_eq({tag, " out_valid_after_hs"}, 32'(out_valid[d]), 32'd0);
    check_eq({tag, " in_ready_after_hs"}, 32'(in_ready[d]), 32'd1);
  endtask

  task automatic check_reset_vals(input string tag);
    for (int d = 0; d < 2; d++) begin
      check_eq({tag, " in_ready"},  32'(in_ready[d]),  32'd1);
      check_eq({tag, " out_valid"}, 32'(out_valid[d]), 32'd0);
      check_eq({tag, " busy"},      32'(busy[d]),      32'd0);
      check_eq({tag, " y"},         y[d],              32'd0);
    end
  endtask

  task automatic rand_operand(output logic [31:0] v);
    v = {1'($urandom_range(0, 1)), 8'($urandom_range(1, 254)),
         23'($urandom_range(0, 32'h7FFFFF))};
  endtask

  // ---------------- stimulus ----------------
  logic [31:0] dir_a   [8] = '{32'h3F800000, 32'h40C00000, 32'h3F800000, 32'hBF800000,
                              32'h3F800000, 32'h00000000, 32'h00800000, 32'h7F000000};
  logic [31:0] dir_b   [8] = '{32'h3F800000, 32'h40000000, 32'h40400000, 32'h40000000,
                              32'h00000000, 32'h40000000, 32'h7F000000, 32'h00800000};
  logic [31:0] dir_exp [8] = '{32'h3F800000, 32'h40400000, 32'h3EAAAAAB, 32'hBF000000,
                              32'h7F800000, 32'h00000000, 32'h00000000, 32'h7F800000};

  initial begin
    logic [31:0] ra, rb;
    logic        ov_seen;
    rstn = 1'b0;
    x1 = '0; x2 = '0;
    for (int d = 0; d < 2; d++) begin
      in_valid[d] = 1'b0;
      out_ready[d] = 1'b0;
    end
    #12;
    check_reset_vals("reset");
    @(negedge clk);
    rstn = 1'b1;

    // Directed vectors on both radices; first one on RADIX=1 with backpressure.
    for (int d = 0; d < 2; d++)
      for (int k = 0; k < 8; k++)
        run_op(d, dir_a[k], dir_b[k], dir_exp[k], (k == 0) ? 10 : 0,
               $sformatf("r%0d_dir%0d", d + 1, k));

    // Random normal operands against the reference model.
    for (int d = 0; d < 2; d++)
      for (int k = 0; k < 12; k++) begin
        rand_operand(ra);
        rand_operand(rb);
        run_op(d, ra, rb, model(ra, rb), int'($urandom_range(0, 3)),
               $sformatf("r%0d_rnd%0d", d + 1, k));
      end

    // Abort mid-CALC: y currently holds a nonzero earlier result.
    @(negedge clk);
    x1 = 32'h3F800000; x2 = 32'h40400000; in_valid[0] = 1'b1;
    @(posedge clk);
    exp_q.push_back(32'h3EAAAAAB);
    @(negedge clk);
    in_valid[0] = 1'b0;
    repeat (9) @(posedge clk);
    #2 rstn = 1'b0;
    #1;
    check_reset_vals("async_reset");
    exp_q.delete();
    ov_seen = 1'b0;
    for (int i = 0; i < 40; i++) begin
      if (i == 3) rstn = 1'b1;
      @(negedge clk);
      if (out_valid[0] || out_valid[1]) ov_seen = 1'b1;
    end
    check_eq("no_out_valid_after_abort", 32'(ov_seen), 32'd0);
    run_op(0, 32'h40C00000, 32'h40000000, 32'h40400000, 0, "post_reset_r1");
    run_op(1, 32'h3F800000, 32'h40400000, 32'h3EAAAAAB, 0, "post_reset_r2");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
